// File: rtl/mux_key_with_default_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_key_with_default_if
// Brief    : Lookup bundle for mux_key_with_default. It carries the key, the
//            default word and the packed table, and returns the registered
//            result and the hit flag.
// Revision : 1.0 - initial release
// ============================================================================
interface mux_key_with_default_if #(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 12,
  parameter int DATA_LEN = 32
) ();

  logic [KEY_LEN-1:0]                     key;
  logic [DATA_LEN-1:0]                    default_out;
  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]   lut;
  logic [DATA_LEN-1:0]                    out;
  logic                                   hit;

  // Requester side: supplies the key and the table, consumes the result
  modport master (
    output key,
    output default_out,
    output lut,
    input  out,
    input  hit
  );

  // Lookup side: consumes the key and the table, produces the result
  modport slave (
    input  key,
    input  default_out,
    input  lut,
    output out,
    output hit
  );

endinterface
`default_nettype wire

// File: rtl/mux_key_with_default.sv
`default_nettype none
// ============================================================================
// Module   : mux_key_with_default
// Brief    : Key/data lookup multiplexer with a registered output. The lowest
//            matching table entry wins. On a miss the caller-supplied default
//            word is returned.
// Revision : 1.0 - initial release
// ============================================================================
module mux_key_with_default #(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 12,
  parameter int DATA_LEN = 32
) (
  input  wire logic              clk,
  input  wire logic              rst,
  mux_key_with_default_if.slave  bus
);

  localparam int c_entry_w = KEY_LEN + DATA_LEN;

  logic [KEY_LEN-1:0]  w_key_tab  [NR_KEY];
  logic [DATA_LEN-1:0] w_data_tab [NR_KEY];
  logic [NR_KEY-1:0]   w_match;
  logic [DATA_LEN-1:0] w_sel_data;
  logic                w_sel_hit;
  logic [DATA_LEN-1:0] r_out;
  logic                r_hit;

  // Unpack each entry (key in the upper bits, data in the lower bits) and
  // compare its key against the input key using exact full-width equality
  generate
    for (genvar gi = 0; gi < NR_KEY; gi++) begin : g_entry
      assign w_key_tab[gi]  = bus.lut[gi*c_entry_w + DATA_LEN +: KEY_LEN];
      assign w_data_tab[gi] = bus.lut[gi*c_entry_w +: DATA_LEN];
      assign w_match[gi]    = (bus.key == w_key_tab[gi]);
    end
  endgenerate

  // Priority select: walk from the top index down so that the lowest matching
  // entry is written last and wins. Data is never OR-merged, so the data of a
  // non-matching entry cannot disturb the result.
  always_comb begin
    w_sel_hit  = |w_match;
    w_sel_data = bus.default_out;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_sel_data = w_data_tab[i];
      end
    end
  end

  // One-cycle result register. Reset clears it at once; no pending result
  // survives a reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out <= '0;
      r_hit <= 1'b0;
    end else begin
      r_out <= w_sel_data;
      r_hit <= w_sel_hit;
    end
  end

  assign bus.out = r_out;
  assign bus.hit = r_hit;

endmodule
`default_nettype wire

// File: tb/tb_mux_key_with_default.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_key_with_default
// Brief    : Self-checking bench for mux_key_with_default. It drives a CSR-style
//            4-entry instance and a 1-entry 2-bit-key instance side by side.
//            Expected results are queued when inputs are driven and compared
//            one clock later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_key_with_default;

  localparam int NR_KEY   = 4;
  localparam int KEY_LEN  = 12;
  localparam int DATA_LEN = 32;
  localparam int W        = KEY_LEN + DATA_LEN;
  localparam int S_NR     = 1;
  localparam int S_KL     = 2;
  localparam int S_DL     = 8;

  typedef struct {
    logic [DATA_LEN-1:0] out;
    logic                hit;
  } exp_t;

  typedef struct {
    logic [S_DL-1:0] out;
    logic            hit;
  } sexp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  mux_key_with_default_if #(.NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN)) bus ();
  mux_key_with_default_if #(.NR_KEY(S_NR), .KEY_LEN(S_KL), .DATA_LEN(S_DL)) sbus ();

  mux_key_with_default #(.NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mux_key_with_default #(.NR_KEY(S_NR), .KEY_LEN(S_KL), .DATA_LEN(S_DL)) u_dut_small (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  // Stimulus state owned by the bench
  logic [KEY_LEN-1:0]    t_key;
  logic [DATA_LEN-1:0]   t_dflt;
  logic [NR_KEY*W-1:0]   t_lut;
  logic [S_KL-1:0]       s_key;
  logic [S_DL-1:0]       s_dflt;
  logic [S_NR*(S_KL+S_DL)-1:0] s_lut;

  exp_t  sb_q [$];
  sexp_t ssb_q [$];
  exp_t  last;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: first (lowest-index) matching entry, else the default word
  function automatic exp_t model(input logic [KEY_LEN-1:0] k,
                                 input logic [DATA_LEN-1:0] d,
                                 input logic [NR_KEY*W-1:0] l);
    exp_t r;
    r.out = d;
    r.hit = 1'b0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (!r.hit && (l[i*W + DATA_LEN +: KEY_LEN] == k)) begin
        r.out = l[i*W +: DATA_LEN];
        r.hit = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic sexp_t smodel(input logic [S_KL-1:0] k);
    sexp_t r;
    r.hit = (k == s_lut[S_DL +: S_KL]);
    r.out = r.hit ? s_lut[S_DL-1:0] : s_dflt;
    return r;
  endfunction

  // Drive one lookup, check that the output still holds the previous result
  // until the edge, then check the queued result one edge later.
  // use_exp = 1 pushes the given constant expectation, otherwise the model's.
  task automatic cycle(input string tag, input bit use_exp,
                       input logic [DATA_LEN-1:0] exp_out, input logic exp_hit);
    exp_t  e;
    exp_t  got;
    sexp_t se;
    sexp_t sgot;
    bus.key          = t_key;
    bus.default_out  = t_dflt;
    bus.lut          = t_lut;
    sbus.key         = s_key;
    sbus.default_out = s_dflt;
    sbus.lut         = s_lut;
    if (use_exp) begin
      e.out = exp_out;
      e.hit = exp_hit;
    end else begin
      e = model(t_key, t_dflt, t_lut);
    end
    sb_q.push_back(e);
    ssb_q.push_back(smodel(s_key));
    #1;
    check({tag, "_hold_out"}, 64'(bus.out), 64'(last.out));
    check({tag, "_hold_hit"}, 64'(bus.hit), 64'(last.hit));
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    se  = ssb_q.pop_front();
    check({tag, "_out"}, 64'(bus.out), 64'(got.out));
    check({tag, "_hit"}, 64'(bus.hit), 64'(got.hit));
    sgot = se;
    check({tag, "_s_out"}, 64'(sbus.out), 64'(sgot.out));
    check({tag, "_s_hit"}, 64'(sbus.hit), 64'(sgot.hit));
    last = got;
  endtask

  logic [KEY_LEN-1:0] keys [4];
  logic [NR_KEY*W-1:0] csr_lut;

  initial begin
    keys[0] = 12'h300;
    keys[1] = 12'h305;
    keys[2] = 12'h341;
    keys[3] = 12'h342;
    csr_lut = {12'h300, 32'h00001800, 12'h305, 32'h80000000,
               12'h341, 32'h80000104, 12'h342, 32'h0000000B};

    // Reset held with arbitrary inputs: outputs must stay cleared
    t_key  = 12'h300;
    t_dflt = 32'hDEADBEEF;
    t_lut  = csr_lut;
    s_key  = 2'd2;
    s_dflt = 8'h5A;
    s_lut  = {2'd2, 8'hA5};
    bus.key = t_key;  bus.default_out = t_dflt;  bus.lut = t_lut;
    sbus.key = s_key; sbus.default_out = s_dflt; sbus.lut = s_lut;
    last.out = '0;
    last.hit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_out", 64'(bus.out), 64'h0);
      check("rst_hit", 64'(bus.hit), 64'h0);
      check("rst_s_out", 64'(sbus.out), 64'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    s_key = 2'd0;

    // Basic lookups against the CSR table
    t_dflt = 32'h0;
    t_key = 12'h300; cycle("k300", 1'b1, 32'h00001800, 1'b1);
    t_key = 12'h342; cycle("k342", 1'b1, 32'h0000000B, 1'b1);
    t_key = 12'h341; cycle("k341", 1'b1, 32'h80000104, 1'b1);

    // Misses return the default word
    t_dflt = 32'hDEADBEEF; t_key = 12'h301; cycle("miss_dflt", 1'b1, 32'hDEADBEEF, 1'b0);
    t_dflt = 32'h0;        t_key = 12'h000; cycle("miss_zero", 1'b1, 32'h00000000, 1'b0);

    // Duplicate key in entries 0 and 2: entry 0 wins
    t_lut = {12'h300, 32'h00001800, 12'h305, 32'h22222222,
             12'h341, 32'h80000104, 12'h305, 32'h11111111};
    t_key = 12'h305; cycle("dup", 1'b1, 32'h11111111, 1'b1);

    // Table data change with a fixed key is visible one edge later
    t_lut = csr_lut;
    cycle("mtvec_old", 1'b1, 32'h80000000, 1'b1);
    t_lut[2*W +: DATA_LEN] = 32'h80001000;
    cycle("mtvec_new", 1'b1, 32'h80001000, 1'b1);
    t_lut = csr_lut;

    // Key toggling every cycle across all four CSRs
    for (int i = 0; i < 8; i++) begin
      t_key = keys[i % 4];
      cycle("toggle", 1'b0, '0, 1'b0);
    end

    // Small instance: exhaustive keys against the single entry
    for (int k = 0; k < 4; k++) begin
      s_key = 2'(k);
      cycle("sweep", 1'b0, '0, 1'b0);
    end

    // Random tables with deliberate key collisions and misses
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < NR_KEY; i++) begin
        t_lut[i*W +: W] = {keys[$urandom_range(0, 3)], 32'($urandom)};
      end
      t_dflt = 32'($urandom);
      t_key  = ($urandom_range(0, 3) == 0) ? 12'($urandom) : keys[$urandom_range(0, 3)];
      s_key  = 2'($urandom_range(0, 3));
      cycle("rand", 1'b0, '0, 1'b0);
    end

    // Asynchronous reset mid-cycle with a valid result showing
    t_lut = csr_lut; t_key = 12'h300; t_dflt = 32'h0; s_key = 2'd2;
    cycle("pre_rst", 1'b1, 32'h00001800, 1'b1);
    t_key = 12'h341;
    bus.key = t_key;
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_out", 64'(bus.out), 64'h0);
    check("async_rst_hit", 64'(bus.hit), 64'h0);
    check("async_rst_s_out", 64'(sbus.out), 64'h0);
    check("async_rst_s_hit", 64'(sbus.hit), 64'h0);
    @(posedge clk);
    #1;
    check("rst_edge_out", 64'(bus.out), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    last.out = '0;
    last.hit = 1'b0;
    t_key = 12'h342; cycle("post_rst", 1'b1, 32'h0000000B, 1'b1);
    t_key = 12'h305; cycle("post_rst2", 1'b1, 32'h80000000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case the stimulus never completes
  initial begin
    #100000;
    $display("FAIL timeout: got no end of test, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/mux_key_with_default.md
Name: mux_key_with_default

Overview:
- Parameterised key-lookup multiplexer with registered output.
- Compares an input key against NR_KEY packed key/data pairs and returns the data of the matching pair. If no pair matches, it returns a caller-supplied default.
- Used in the register-file/CSR path, e.g. mapping a 12-bit CSR address to its 32-bit CSR value: keys 0x300, 0x305, 0x341, 0x342 select mstatus, mtvec, mepc, mcause.

Parameters:
- NR_KEY, 4, number of key/data pairs in the lookup table (≥1).
- KEY_LEN, 12, width of each key in bits (≥1).
- DATA_LEN, 32, width of each data word and of the output (≥1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- key  input  KEY_LEN  lookup key.
- default_out  input  DATA_LEN  value returned when no table key matches.
- lut  input  NR_KEY*(KEY_LEN+DATA_LEN)  packed lookup table.
- out  output  DATA_LEN  registered lookup result.
- hit  output  1  registered match flag: 1 if any table key equalled key.

Behaviour:
- Table packing. Let W = KEY_LEN + DATA_LEN.
  - Entry i (0..NR_KEY-1) occupies lut[(i+1)*W-1 : i*W].
  - Within an entry, the key is the upper KEY_LEN bits and the data is the lower DATA_LEN bits.
  - Entry 0 is therefore the least-significant pair, i.e. the last pair in a concatenation such as {k3,d3,k2,d2,k1,d1,k0,d0}.
- Match logic (combinational):
  - match_i = (key == key_i), full-width equality, no don't-care bits.
  - sel_hit = OR of all match_i.
  - sel_data = data of the lowest-index matching entry; default_out if no entry matches.
- Duplicate keys: the lowest index wins. Data from other matching entries never affects out (no OR-merging).
- Register stage:
  - On each rising clk with rst high: out <= sel_data, hit <= sel_hit.
  - Latency is exactly 1 cycle from key/lut/default_out to out/hit.
  - No enable and no handshake; the block samples every cycle.
- Reset:
  - While rst is low, out = 0 and hit = 0 immediately, asynchronous to clk.
  - Reset deassertion takes effect at the next rising edge, which loads the current lookup.
  - Reset asserted mid-operation discards any pending result; no partial state remains.
- lut and default_out are sampled at the same edge as key. A change to table data is visible one cycle later even if key is unchanged.
- No X-propagation masking is required. If key is known and matches, out must be fully known regardless of the data in non-matching entries.
- Width rules: no truncation or extension; out is exactly DATA_LEN bits. NR_KEY=1 must work: the output is either the single entry's data or the default.

Test Plan:
- Reset: hold rst=0 with arbitrary inputs for several cycles → out=0x00000000, hit=0. Assert rst low asynchronously mid-cycle after valid outputs → out and hit drop to 0 without a clock edge.
- Basic lookup (defaults): lut={0x300,0x00001800, 0x305,0x80000000, 0x341,0x80000104, 0x342,0x0000000B}, default_out=0.
  - key=0x300 → after 1 edge out=0x00001800, hit=1.
  - key=0x342 → out=0x0000000B, hit=1.
  - key=0x341 → out=0x80000104, hit=1.
- Miss: same lut, default_out=0xDEADBEEF, key=0x301 → out=0xDEADBEEF, hit=0. With default_out=0 and key=0x000 → out=0, hit=0.
- Duplicate priority: entries 0 and 2 both key 0x305, data 0x11111111 (entry 0) and 0x22222222 (entry 2), key=0x305 → out=0x11111111, hit=1.
- Latency/table update: hold key=0x305 and change mtvec data 0x80000000→0x80001000 at edge N → out shows 0x80000000 through edge N and 0x80001000 after edge N+1. Toggle key every cycle across all four keys → out tracks with exactly 1-cycle delay.
- Parameter sweep: NR_KEY=1, KEY_LEN=2, DATA_LEN=8; exhaustive keys 0..3 against single entry key=2, data=0xA5, default=0x5A → out=0xA5 only for key=2, else 0x5A.
